// File: rtl/sdram_ctrlmod_pq.sv
// sdram_ctrlmod_pq: arbitrates caller write/read requests onto the SDRAM
// function module and issues the initial and periodic auto-refresh calls.
// Write/read addresses form a circular queue (WP/RP with one wrap bit).
// Ports:
//   CLOCK, RESET  clock (rising edge), asynchronous active-low reset
//   iCall[1:0]    caller requests: [1] write, [0] read (level, held to oDone)
//   oDone[1:0]    per-request completion pulse to the caller
//   oCall[3:0]    to function module: [3] write [2] read [1] refresh [0] init
//   iDone         function-module completion pulse
//   oAddr         transfer address, latched when a call is issued
//   iClear        queue flush, honoured only in IDLE
//   oTag[1:0]     [1] full, [0] empty (combinational)
//   oCount        queue occupancy WP - RP (combinational)
module sdram_ctrlmod_pq #(
  parameter int unsigned AW    = 24,
  parameter int unsigned TREF  = 1040,
  parameter int unsigned STEP  = 1,
  parameter int unsigned RR_EN = 1
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [1:0]    iCall,
  output logic [1:0]    oDone,
  output logic [3:0]    oCall,
  input  logic          iDone,
  output logic [AW-1:0] oAddr,
  input  logic          iClear,
  output logic [1:0]    oTag,
  output logic [AW:0]   oCount
);

  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW_RAW = $clog2(TREF + 1);
  localparam int unsigned CW     = (CW_RAW < 11) ? 11 : ((CW_RAW > 16) ? 16 : CW_RAW);
  localparam logic [PW-1:0] STEP_P = PW'(STEP);
  localparam logic [CW-1:0] TREF_C = CW'(TREF);
  localparam bit            RR     = (RR_EN != 0);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WCALL, S_WDONE, S_RCALL, S_RDONE, S_REF
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    call_q, call_d;
  logic [1:0]    done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] c1_q, c1_d;
  logic [1:0]    pend_q, pend_d;
  logic          lw_q, lw_d;   // 1 = write was served last

  logic full_c, empty_c, w_elig_c, r_elig_c, pick_w_c;

  // Queue flags and arbitration decision
  assign full_c   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_c  = (wp_q == rp_q);
  assign w_elig_c = pend_q[1] && !full_c;
  assign r_elig_c = pend_q[0] && !empty_c;
  assign pick_w_c = w_elig_c && (!r_elig_c || !RR || !lw_q);

  // State and datapath registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_INIT;
      call_q  <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      c1_q    <= '0;
      pend_q  <= '0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      call_q  <= call_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      c1_q    <= c1_d;
      pend_q  <= pend_d;
      lw_q    <= lw_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    call_d  = call_q;
    done_d  = 2'b00;
    addr_d  = addr_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    lw_d    = lw_q;
    // A held request must not re-arm in the cycle its done pulse is out
    pend_d  = (pend_q | iCall) & ~done_q;
    // Refresh interval counter, saturating; frozen during INITIAL/REFRESH
    if (state_q == S_INIT || state_q == S_REF) begin
      c1_d = c1_q;
    end else if (c1_q < TREF_C) begin
      c1_d = c1_q + CW'(1);
    end else begin
      c1_d = c1_q;
    end

    case (state_q)
      S_INIT: begin
        c1_d   = '0;
        call_d = 4'b0001;
        if (iDone) begin
          call_d  = 4'b0000;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (c1_q >= TREF_C) begin
          c1_d    = '0;
          call_d  = 4'b0010;
          state_d = S_REF;
        end else if (iClear) begin
          wp_d = '0;
          rp_d = '0;
        end else if (pick_w_c) begin
          call_d  = 4'b1000;
          addr_d  = wp_q[AW-1:0];
          state_d = S_WCALL;
        end else if (r_elig_c) begin
          call_d  = 4'b0100;
          addr_d  = rp_q[AW-1:0];
          state_d = S_RCALL;
        end
      end
      S_WCALL: begin
        if (iDone) begin
          call_d  = 4'b0000;
          done_d  = 2'b10;
          state_d = S_WDONE;
        end
      end
      S_WDONE: begin
        wp_d    = wp_q + STEP_P;
        lw_d    = 1'b1;
        state_d = S_IDLE;
      end
      S_RCALL: begin
        if (iDone) begin
          call_d  = 4'b0000;
          done_d  = 2'b01;
          state_d = S_RDONE;
        end
      end
      S_RDONE: begin
        rp_d    = rp_q + STEP_P;
        lw_d    = 1'b0;
        state_d = S_IDLE;
      end
      S_REF: begin
        if (iDone) begin
          call_d  = 4'b0000;
          state_d = S_IDLE;
        end
      end
      default: begin
        call_d  = 4'b0000;
        state_d = S_INIT;
      end
    endcase
  end

  assign oCall  = call_q;
  assign oDone  = done_q;
  assign oAddr  = addr_q;
  assign oTag   = {full_c, empty_c};
  assign oCount = wp_q - rp_q;

endmodule

// File: tb/tb_sdram_ctrlmod_pq.sv
// tb_sdram_ctrlmod_pq: directed bench for sdram_ctrlmod_pq.
// Instance A: AW=4, STEP=1, TREF=20, round-robin.
// Instance B: AW=6, STEP=8, TREF=1040, fixed write priority.
// A function-module responder answers every call with iDone 5 cycles later.
module tb_sdram_ctrlmod_pq;

  logic       clk;
  logic       rst_a, rst_b;

  logic [1:0] a_icall, a_odone, a_otag;
  logic [3:0] a_ocall, a_oaddr;
  logic       a_idone, a_iclear;
  logic [4:0] a_ocount;

  logic [1:0] b_icall, b_odone, b_otag;
  logic [3:0] b_ocall;
  logic [5:0] b_oaddr;
  logic       b_idone, b_iclear;
  logic [6:0] b_ocount;

  int n_vec;
  int n_err;

  sdram_ctrlmod_pq #(.AW(4), .TREF(20), .STEP(1), .RR_EN(1)) u_dut_a (
    .CLOCK(clk), .RESET(rst_a), .iCall(a_icall), .oDone(a_odone),
    .oCall(a_ocall), .iDone(a_idone), .oAddr(a_oaddr), .iClear(a_iclear),
    .oTag(a_otag), .oCount(a_ocount)
  );

  sdram_ctrlmod_pq #(.AW(6), .TREF(1040), .STEP(8), .RR_EN(0)) u_dut_b (
    .CLOCK(clk), .RESET(rst_b), .iCall(b_icall), .oDone(b_odone),
    .oCall(b_ocall), .iDone(b_idone), .oAddr(b_oaddr), .iClear(b_iclear),
    .oTag(b_otag), .oCount(b_ocount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Function-module responders: iDone pulse 5 cycles after a call appears
  int a_mcnt, b_mcnt;
  initial begin
    a_idone = 1'b0;
    a_mcnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        a_idone = 1'b0;
        a_mcnt  = 0;
      end else if (a_idone) begin
        a_idone = 1'b0;
      end else if (a_ocall != 4'd0) begin
        if (a_mcnt == 4) begin
          a_idone = 1'b1;
          a_mcnt  = 0;
        end else begin
          a_mcnt++;
        end
      end else begin
        a_mcnt = 0;
      end
    end
  end

  initial begin
    b_idone = 1'b0;
    b_mcnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        b_idone = 1'b0;
        b_mcnt  = 0;
      end else if (b_idone) begin
        b_idone = 1'b0;
      end else if (b_ocall != 4'd0) begin
        if (b_mcnt == 4) begin
          b_idone = 1'b1;
          b_mcnt  = 0;
        end else begin
          b_mcnt++;
        end
      end else begin
        b_mcnt = 0;
      end
    end
  end

  // Per-cycle monitors: call exclusivity, call/done overlap, refresh spacing
  int         cyc;
  int         a_last_fall;
  int         gap;
  logic [3:0] a_prev, b_prev;
  bit         seen_w_a, seen_r_a, seen_w_b;

  initial begin
    cyc = 0; a_last_fall = 0; a_prev = 4'd0; b_prev = 4'd0;
    seen_w_a = 1'b0; seen_r_a = 1'b0; seen_w_b = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_a) begin
        chk("a_call_onehot0", 32'($countones(a_ocall) <= 1), 32'd1);
        chk("a_call_done_overlap",
            32'((a_ocall[3] & a_odone[1]) | (a_ocall[2] & a_odone[0])), 32'd0);
        if (a_ocall[3]) seen_w_a = 1'b1;
        if (a_ocall[2]) seen_r_a = 1'b1;
        if ((a_prev[1] | a_prev[0]) && !(a_ocall[1] | a_ocall[0])) a_last_fall = cyc;
        if (a_ocall[1] && !a_prev[1]) begin
          gap = cyc - a_last_fall;
          chk($sformatf("a_refresh_gap_%0d_in_21_30", gap), 32'(gap >= 21 && gap <= 30), 32'd1);
        end
        a_prev = a_ocall;
      end else begin
        a_prev = 4'd0;
      end
      if (rst_b) begin
        chk("b_call_onehot0", 32'($countones(b_ocall) <= 1), 32'd1);
        chk("b_call_done_overlap",
            32'((b_ocall[3] & b_odone[1]) | (b_ocall[2] & b_odone[0])), 32'd0);
        if (b_ocall[3]) seen_w_b = 1'b1;
        b_prev = b_ocall;
      end else begin
        b_prev = 4'd0;
      end
    end
  end

  // Caller-side helpers for instance A
  task automatic a_wait_done(input int kind, input int exp_addr);
    int n;
    n = 0;
    while (!a_odone[kind] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("a_done%0d_seen", kind), 32'(a_odone[kind]), 32'd1);
    chk($sformatf("a_addr_k%0d", kind), 32'(a_oaddr), 32'(exp_addr));
  endtask

  task automatic a_xfer(input int kind, input int exp_addr);
    a_icall[kind] = 1'b1;
    a_wait_done(kind, exp_addr);
    a_icall[kind] = 1'b0;
    @(negedge clk);
  endtask

  task automatic a_grant(input logic [1:0] exp_done, input int exp_addr, input bit drop);
    int n;
    n = 0;
    while (a_odone == 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("a_grant_kind", 32'(a_odone), 32'(exp_done));
    chk("a_grant_addr", 32'(a_oaddr), 32'(exp_addr));
    if (drop) a_icall = a_icall & ~a_odone;
    @(negedge clk);
  endtask

  task automatic a_wait_init();
    int n;
    n = 0;
    while (a_ocall != 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_init_released", 32'(a_ocall), 32'd0);
  endtask

  // Caller-side helpers for instance B
  task automatic b_wait_done(input int kind, input int exp_addr);
    int n;
    n = 0;
    while (!b_odone[kind] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("b_done%0d_seen", kind), 32'(b_odone[kind]), 32'd1);
    chk($sformatf("b_addr_k%0d", kind), 32'(b_oaddr), 32'(exp_addr));
  endtask

  task automatic b_xfer(input int kind, input int exp_addr);
    b_icall[kind] = 1'b1;
    b_wait_done(kind, exp_addr);
    b_icall[kind] = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_grant(input logic [1:0] exp_done, input int exp_addr);
    int n;
    n = 0;
    while (b_odone == 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b_grant_kind", 32'(b_odone), 32'(exp_done));
    chk("b_grant_addr", 32'(b_oaddr), 32'(exp_addr));
    b_icall = b_icall & ~b_odone;
    @(negedge clk);
  endtask

  task automatic b_wait_init();
    int n;
    n = 0;
    while (b_ocall != 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_init_released", 32'(b_ocall), 32'd0);
  endtask

  int rr_kind [5];
  int rr_addr [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    a_icall = 2'b00; a_iclear = 1'b0;
    b_icall = 2'b00; b_iclear = 1'b0;
    rr_kind = '{1, 0, 1, 0, 1};
    rr_addr = '{1, 9, 2, 10, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("a_rst_call",  32'(a_ocall),  32'd0);
    chk("a_rst_done",  32'(a_odone),  32'd0);
    chk("a_rst_addr",  32'(a_oaddr),  32'd0);
    chk("a_rst_tag",   32'(a_otag),   32'd1);
    chk("a_rst_count", 32'(a_ocount), 32'd0);
    chk("b_rst_call",  32'(b_ocall),  32'd0);
    chk("b_rst_tag",   32'(b_otag),   32'd1);

    // Release: INITIAL call first, then IDLE with an empty queue
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("a_init_call", 32'(a_ocall), 32'd1);
    chk("b_init_call", 32'(b_ocall), 32'd1);
    a_wait_init();
    b_wait_init();
    chk("a_idle_tag",   32'(a_otag),   32'd1);
    chk("a_idle_count", 32'(a_ocount), 32'd0);

    // Read while empty stays pending; a write then unblocks it
    seen_r_a = 1'b0;
    a_icall[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("a_read_empty_blocked", 32'(seen_r_a), 32'd0);
    a_xfer(1, 0);
    a_wait_done(0, 0);
    a_icall[0] = 1'b0;
    @(negedge clk);
    chk("a_after_rw_tag",   32'(a_otag),   32'd1);
    chk("a_after_rw_count", 32'(a_ocount), 32'd0);

    // Flush pointers back to zero (held across any refresh)
    a_iclear = 1'b1;
    repeat (12) @(negedge clk);
    a_iclear = 1'b0;
    @(negedge clk);

    // Sixteen writes fill the queue
    for (int i = 0; i < 16; i++) a_xfer(1, i);
    chk("a_full_tag",   32'(a_otag),   32'd2);
    chk("a_full_count", 32'(a_ocount), 32'd16);

    // Seventeenth write waits until a read frees a slot
    seen_w_a = 1'b0;
    a_icall[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("a_write_full_blocked", 32'(seen_w_a), 32'd0);
    a_xfer(0, 0);
    a_wait_done(1, 0);
    a_icall[1] = 1'b0;
    @(negedge clk);
    chk("a_refull_tag",   32'(a_otag),   32'd2);
    chk("a_refull_count", 32'(a_ocount), 32'd16);

    // Drain to half full
    for (int i = 1; i <= 8; i++) a_xfer(0, i);
    chk("a_half_count", 32'(a_ocount), 32'd8);

    // Both held: grants alternate W, R, W, R, W
    a_icall = 2'b11;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) a_grant(2'b01, rr_addr[k], 1'b0);
      else a_grant((rr_kind[k] == 1) ? 2'b10 : 2'b01, rr_addr[k], 1'b0);
      if (k == 3) a_icall[0] = 1'b0;
      if (k == 4) a_icall[1] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Simultaneous requests after a write: round-robin serves read first
    a_icall = 2'b11;
    a_grant(2'b01, 11, 1'b1);
    a_grant(2'b10, 4, 1'b1);
    chk("a_rr_count", 32'(a_ocount), 32'd9);
    chk("a_rr_tag",   32'(a_otag),   32'd0);

    // Instance B: STEP=8 fills in eight writes
    for (int i = 0; i < 8; i++) b_xfer(1, i * 8);
    chk("b_full_tag",   32'(b_otag),   32'd2);
    chk("b_full_count", 32'(b_ocount), 32'd64);
    b_xfer(0, 0);
    b_xfer(0, 8);
    b_xfer(1, 0);
    chk("b_count_56", 32'(b_ocount), 32'd56);

    // Simultaneous requests after a write: fixed priority serves write again
    repeat (2) @(negedge clk);
    b_icall = 2'b11;
    b_grant(2'b10, 8);
    b_grant(2'b01, 16);
    chk("b_fixed_count", 32'(b_ocount), 32'd56);
    chk("b_fixed_tag",   32'(b_otag),   32'd0);

    // Queue clear in IDLE
    b_iclear = 1'b1;
    repeat (12) @(negedge clk);
    b_iclear = 1'b0;
    @(negedge clk);
    chk("b_clear_count", 32'(b_ocount), 32'd0);
    chk("b_clear_tag",   32'(b_otag),   32'd1);

    // Reset dropped in the middle of a write call
    b_xfer(1, 0);
    b_icall[1] = 1'b1;
    for (int n = 0; n < 40 && !b_ocall[3]; n++) @(negedge clk);
    chk("b_wcall_active", 32'(b_ocall), 32'd8);
    chk("b_wcall_addr",   32'(b_oaddr), 32'd8);
    rst_b = 1'b0;
    #1;
    chk("b_midrst_call",  32'(b_ocall),  32'd0);
    chk("b_midrst_done",  32'(b_odone),  32'd0);
    chk("b_midrst_addr",  32'(b_oaddr),  32'd0);
    chk("b_midrst_tag",   32'(b_otag),   32'd1);
    chk("b_midrst_count", 32'(b_ocount), 32'd0);
    b_icall = 2'b00;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_reinit_call", 32'(b_ocall), 32'd1);
    b_wait_init();
    seen_w_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("b_no_stale_write", 32'(seen_w_b), 32'd0);
    chk("b_reinit_count",   32'(b_ocount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
